// File: rtl/fir_decim_out.sv
// rtl/fir_decim_out.sv - FIR output decimator feeding a 2-entry FIFO with overflow tracking
// Keeps one of every M valid samples; kept samples are buffered bit-exact.
module fir_decim_out #(
  parameter int BITWIDTH = 16,
  parameter int DWIDTH   = 8,
  parameter int CNTWIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic signed [BITWIDTH-1:0] in_data,
  input  logic        [DWIDTH-1:0]   decim,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [BITWIDTH-1:0] out_data,
  output logic                       overflow,
  input  logic                       clear_ovf,
  output logic        [CNTWIDTH-1:0] drop_count
);

  logic [DWIDTH-1:0]   phase_q, phase_d;
  logic [DWIDTH-1:0]   m_act_q, m_act_d;
  logic [BITWIDTH-1:0] ent0_q, ent0_d;
  logic [BITWIDTH-1:0] ent1_q, ent1_d;
  logic [1:0]          count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [CNTWIDTH-1:0] dcnt_q, dcnt_d;

  logic [DWIDTH-1:0] decim_eff;
  logic              keep, pop, drop;

  assign decim_eff = (decim == '0) ? DWIDTH'(1) : decim;
  assign keep      = in_valid && (phase_q == '0);
  assign pop       = (count_q != 2'd0) && out_ready;
  assign drop      = keep && (count_q == 2'd2) && !pop;

  always_comb begin
    phase_d = phase_q;
    m_act_d = m_act_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    dcnt_d  = dcnt_q;

    // The period only changes at a wrap, so mid-period decim edits are deferred.
    if (in_valid) begin
      if (phase_q == m_act_q - DWIDTH'(1)) begin
        phase_d = '0;
        m_act_d = decim_eff;
      end else begin
        phase_d = phase_q + DWIDTH'(1);
      end
    end

    // ent0 is the head; it keeps its value after the last pop so out_data holds.
    if (keep && pop) begin
      if (count_q == 2'd1) begin
        ent0_d = in_data;
      end else begin
        ent0_d = ent1_q;
        ent1_d = in_data;
      end
    end else if (keep) begin
      if (count_q == 2'd0) begin
        ent0_d  = in_data;
        count_d = 2'd1;
      end else if (count_q == 2'd1) begin
        ent1_d  = in_data;
        count_d = 2'd2;
      end
    end else if (pop) begin
      if (count_q == 2'd2) begin
        ent0_d = ent1_q;
      end
      count_d = count_q - 2'd1;
    end

    if (clear_ovf) begin
      ovf_d  = drop;
      dcnt_d = drop ? CNTWIDTH'(1) : '0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (dcnt_q != '1) begin
        dcnt_d = dcnt_q + CNTWIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      m_act_q <= decim_eff;
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= 2'd0;
      ovf_q   <= 1'b0;
      dcnt_q  <= '0;
    end else begin
      phase_q <= phase_d;
      m_act_q <= m_act_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign out_valid  = (count_q != 2'd0);
  assign out_data   = ent0_q;
  assign overflow   = ovf_q;
  assign drop_count = dcnt_q;

endmodule

// File: tb/tb_fir_decim_out.sv
// tb/tb_fir_decim_out.sv - self-checking bench for fir_decim_out
// Directed scenarios plus randomized traffic against a queue-based reference model.
module tb_fir_decim_out;

  localparam int BW = 16;
  localparam int DW = 8;
  localparam int CW = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic signed [BW-1:0] in_data;
  logic [DW-1:0]        decim;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [BW-1:0] out_data;
  logic                 overflow;
  logic                 clear_ovf;
  logic [CW-1:0]        drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: samples until the next keep, active period, FIFO as a queue.
  int          m_until;
  int          m_period;
  logic [BW-1:0] m_q[$];
  logic [BW-1:0] m_last;
  bit          m_ovf;
  int          m_cnt;

  fir_decim_out #(.BITWIDTH(BW), .DWIDTH(DW), .CNTWIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .decim(decim),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .overflow(overflow), .clear_ovf(clear_ovf), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  function automatic int eff(input logic [DW-1:0] d);
    return (d == 0) ? 1 : int'(d);
  endfunction

  task automatic model_step();
    bit dropped;
    dropped = 0;
    if (rst) begin
      m_q.delete();
      m_last = '0; m_ovf = 0; m_cnt = 0;
      m_until = 0; m_period = eff(decim);
    end else begin
      if (m_q.size() > 0 && out_ready) m_last = m_q.pop_front();
      if (in_valid && m_until == 0) begin
        if (m_q.size() < 2) m_q.push_back(in_data);
        else dropped = 1;
      end
      if (clear_ovf) begin
        m_ovf = dropped; m_cnt = dropped ? 1 : 0;
      end else if (dropped) begin
        m_ovf = 1; m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      end
      if (in_valid) begin
        if (m_until == 0) begin
          // keep taken: next keep after period-1 more samples, period re-sampled at wrap
          m_until = m_period - 1;
          if (m_until == 0) m_period = eff(decim);
        end else begin
          m_until = m_until - 1;
          if (m_until == 0) m_period = eff(decim);
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_data = '0; clear_ovf = 0; rst = 0;
  endtask

  task automatic do_reset(input logic [DW-1:0] d);
    decim = d; rst = 1; in_valid = 0; clear_ovf = 0; out_ready = 0;
    tick(); tick();
    rst = 0;
  endtask

  task automatic push(input int v);
    in_valid = 1; in_data = BW'(v);
    tick();
    in_valid = 0;
  endtask

  task automatic test_reset();
    decim = 8'd1; in_valid = 1; in_data = 16'sd99; out_ready = 1; clear_ovf = 0; rst = 1;
    tick(); tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
    n_checks++; if (out_data !== 16'sd0) begin n_fail++; $display("FAIL reset_data got %0d exp 0", out_data); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b exp 0", overflow); end
    n_checks++; if (drop_count !== 3'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", drop_count); end
    idle_inputs();
  endtask

  task automatic test_decim1();
    do_reset(8'd1);
    out_ready = 1;
    for (int i = 1; i <= 6; i++) begin
      push(i);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== BW'(i)) begin
        n_fail++; $display("FAIL decim1_out got v=%0b d=%0d exp v=1 d=%0d", out_valid, out_data, i);
      end
    end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL decim1_drain got %0b exp 0", out_valid); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL decim1_ovf got %0b exp 0", overflow); end
  endtask

  task automatic test_decim4();
    do_reset(8'd4);
    out_ready = 1;
    in_valid = 1;
    for (int i = 10; i <= 21; i++) begin
      bit ev;
      in_data = BW'(i);
      tick();
      ev = ((i - 10) % 4 == 0);
      n_checks++;
      if (out_valid !== ev || (ev && out_data !== BW'(i))) begin
        n_fail++; $display("FAIL decim4_out i=%0d got v=%0b d=%0d exp v=%0b", i, out_valid, out_data, ev);
      end
    end
    in_valid = 0;
  endtask

  task automatic test_overflow_clear();
    do_reset(8'd1);
    out_ready = 0;
    for (int i = 5; i <= 8; i++) push(i);
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'sd5) begin n_fail++; $display("FAIL ovf_hold got v=%0b d=%0d exp v=1 d=5", out_valid, out_data); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %0b exp 1", overflow); end
    n_checks++; if (drop_count !== 3'd2) begin n_fail++; $display("FAIL ovf_cnt got %0d exp 2", drop_count); end
    out_ready = 1;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'sd6) begin n_fail++; $display("FAIL ovf_pop1 got v=%0b d=%0d exp v=1 d=6", out_valid, out_data); end
    tick();
    n_checks++; if (out_valid !== 1'b0 || out_data !== 16'sd6) begin n_fail++; $display("FAIL ovf_pop2 got v=%0b d=%0d exp v=0 d=6", out_valid, out_data); end
    clear_ovf = 1; tick(); clear_ovf = 0;
    n_checks++; if (overflow !== 1'b0 || drop_count !== 3'd0) begin n_fail++; $display("FAIL clear got ovf=%0b cnt=%0d exp 0 0", overflow, drop_count); end
    // clear and a fresh drop on the same edge
    out_ready = 0;
    push(1); push(2); push(3);
    clear_ovf = 1; push(4); clear_ovf = 0;
    n_checks++; if (overflow !== 1'b1 || drop_count !== 3'd1) begin n_fail++; $display("FAIL clear_drop got ovf=%0b cnt=%0d exp 1 1", overflow, drop_count); end
  endtask

  task automatic test_saturate();
    do_reset(8'd1);
    out_ready = 0;
    for (int i = 0; i < CMAX + 6; i++) push(i);
    n_checks++; if (drop_count !== 3'(CMAX)) begin n_fail++; $display("FAIL saturate got %0d exp %0d", drop_count, CMAX); end
    n_checks++; if (out_data !== 16'sd0) begin n_fail++; $display("FAIL saturate_head got %0d exp 0", out_data); end
  endtask

  task automatic test_push_pop_full();
    do_reset(8'd1);
    out_ready = 0;
    push(5); push(6);
    out_ready = 1;
    push(9);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'sd6) begin n_fail++; $display("FAIL pp_head got v=%0b d=%0d exp v=1 d=6", out_valid, out_data); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'sd9) begin n_fail++; $display("FAIL pp_second got v=%0b d=%0d exp v=1 d=9", out_valid, out_data); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pp_empty got %0b exp 0", out_valid); end
    n_checks++; if (overflow !== 1'b0 || drop_count !== 3'd0) begin n_fail++; $display("FAIL pp_nodrop got ovf=%0b cnt=%0d exp 0 0", overflow, drop_count); end
  endtask

  task automatic test_decim_change();
    logic [BW-1:0] got[$];
    int exp_v[5] = '{0, 3, 5, 7, 9};
    do_reset(8'd3);
    out_ready = 1;
    for (int i = 0; i <= 9; i++) begin
      push(i);
      if (i == 0) decim = 8'd2;
      if (out_valid) got.push_back(out_data);
    end
    n_checks++;
    if (got.size() != 5) begin
      n_fail++; $display("FAIL dchg_count got %0d exp 5", got.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_checks++;
        if (got[k] !== BW'(exp_v[k])) begin n_fail++; $display("FAIL dchg_val k=%0d got %0d exp %0d", k, got[k], exp_v[k]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    do_reset(8'd1);
    out_ready = 0;
    push(41); push(42);
    rst = 1; in_valid = 1; in_data = 16'sd77;
    tick();
    rst = 0; in_valid = 0;
    n_checks++; if (out_valid !== 1'b0 || out_data !== 16'sd0) begin n_fail++; $display("FAIL rmid got v=%0b d=%0d exp v=0 d=0", out_valid, out_data); end
    out_ready = 1; seen = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (out_valid) seen++; end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rmid_flush got %0d outputs exp 0", seen); end
  endtask

  task automatic test_random();
    do_reset(8'd2);
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = BW'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      clear_ovf = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 9) == 0) decim = DW'($urandom_range(0, 5));
      tick();
      n_checks++;
      if (out_valid !== (m_q.size() > 0)) begin n_fail++; $display("FAIL rnd_valid c=%0d got %0b exp %0b", c, out_valid, m_q.size() > 0); end
      n_checks++;
      if (out_data !== ((m_q.size() > 0) ? m_q[0] : m_last)) begin
        n_fail++; $display("FAIL rnd_data c=%0d got %0d exp %0d", c, out_data, (m_q.size() > 0) ? m_q[0] : m_last);
      end
      n_checks++;
      if (overflow !== m_ovf || drop_count !== CW'(m_cnt)) begin
        n_fail++; $display("FAIL rnd_ovf c=%0d got ovf=%0b cnt=%0d exp ovf=%0b cnt=%0d", c, overflow, drop_count, m_ovf, m_cnt);
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1; in_valid = 0; in_data = '0; decim = 8'd1; out_ready = 0; clear_ovf = 0;
    m_q.delete(); m_last = '0; m_ovf = 0; m_cnt = 0; m_until = 0; m_period = 1;
    test_reset();
    test_decim1();
    test_decim4();
    test_overflow_clear();
    test_saturate();
    test_push_pop_full();
    test_decim_change();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_decim_out.md
FIR_DECIM_OUT -- requirements
Module: fir_decim_out

Interface
REQ-001 Parameter BITWIDTH, default 16: sample width; equals the FIR output width.
REQ-002 Parameter DWIDTH, default 8: width of the decimation-factor port.
REQ-003 Parameter CNTWIDTH, default 16: width of the dropped-sample counter.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 in_valid  input  1  marks in_data as a new FIR output sample this cycle.
REQ-007 in_data  input  BITWIDTH (signed)  FIR output sample.
REQ-008 decim  input  DWIDTH  decimation factor M; value 0 treated as 1.
REQ-009 out_valid  output  1  out_data holds a kept sample.
REQ-010 out_ready  input  1  downstream accepts out_data when out_valid is high.
REQ-011 out_data  output  BITWIDTH (signed)  head of the output buffer.
REQ-012 overflow  output  1  sticky flag: a kept sample was dropped.
REQ-013 clear_ovf  input  1  clears overflow and drop_count.
REQ-014 drop_count  output  CNTWIDTH  number of dropped kept samples, saturating.

Function
REQ-015 The block shall keep one of every M accepted input samples and shall pass kept samples unmodified (bit-exact) into a 2-entry FIFO.
REQ-016 Phase counter: advances only on in_valid; counts 0..M-1 then wraps to 0.
REQ-017 A sample with in_valid=1 is kept when phase==0.
REQ-018 The first sample after reset shall be kept.
REQ-019 M_active register: loaded from decim (0 mapped to 1) on reset release and whenever the phase wraps to 0; decim changes mid-period have no effect until the next wrap.
REQ-020 With M_active=1, every valid sample shall be kept.
REQ-021 Latency: a kept sample presented in cycle n shall appear on out_data with out_valid=1 in cycle n+1 when the FIFO was empty.
REQ-022 Handshake: a pop occurs when out_valid && out_ready.
REQ-023 out_valid and out_data shall hold stable while out_valid=1 and out_ready=0.
REQ-024 out_valid shall be 1 exactly when the FIFO count is >0.
REQ-025 FIFO order: strictly first-in first-out; out_data is the oldest entry.
REQ-026 Push and pop in the same cycle shall be allowed at any occupancy, including full.
  - Count is unchanged.
  - No drop occurs.
REQ-027 A kept sample arriving with FIFO full (count 2) and no pop that cycle shall be discarded.
  - FIFO contents are unchanged.
  - overflow is set to 1.
  - drop_count increments by 1 and saturates at 2^CNTWIDTH-1.
REQ-028 A non-kept sample shall never affect FIFO, overflow or drop_count.
REQ-029 clear_ovf=1 shall zero overflow and drop_count on the next edge.
  - If a drop occurs in the same cycle, clear wins the flag, then overflow=1 and drop_count=1 (the new drop is recorded).
REQ-030 out_ready is ignored while out_valid=0; a pop on an empty FIFO shall not occur.
REQ-031 When empty, out_data shall hold its last value (0 after reset).

Reset
REQ-032 On a rising clk edge with rst=1:
  - phase=0 and M_active=max(decim,1).
  - FIFO count=0, out_valid=0, out_data=0.
  - overflow=0, drop_count=0.
REQ-033 Reset mid-operation shall discard buffered samples and any in-flight input that cycle; in_valid during rst is ignored.
REQ-034 The first cycle after rst deasserts is a normal operating cycle.

Verification
REQ-035 decim=1, out_ready=1, in_valid every cycle with in_data=1,2,3,... -> out_data=1,2,3,... one cycle later; overflow=0.
REQ-036 decim=4, out_ready=1, in_data=10..21 every cycle -> outputs 10,14,18 only; each appears one cycle after its input.
REQ-037 decim=1, out_ready=0, inputs 5,6,7,8 -> FIFO holds 5,6.
  - overflow=1 and drop_count=2.
  - out_data stays 5 with out_valid=1.
  - Then out_ready=1 -> 5 then 6 delivered, then out_valid=0.
REQ-038 FIFO full (5,6) with out_ready=1 and kept input 9 in the same cycle -> 5 popped, FIFO holds 6,9, no drop.
REQ-039 decim=3 and change decim to 2 after the first kept sample, inputs 0..9 -> kept samples 0, 3, 5, 7, 9.
REQ-040 Overflow present, then clear_ovf pulse -> overflow=0 and drop_count=0.
  - Also: assert rst with 2 entries buffered -> out_valid=0 next cycle and the buffered entries are never output.
